// File: rtl/npc_pkg.sv
// Shared definitions for the next-PC generator: default constants, pending-redirect
// FSM states and the sequential fetch-block successor function.
package npc_pkg;

    localparam int unsigned DEF_PC_W     = 32;
    localparam logic [31:0] DEF_RESET_PC = 32'h1c00_0000;

    typedef enum logic {
        IDLE,
        PEND
    } pend_state_e;

    // Index width for an n-channel encoder; never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Start of the next fetch block; callers truncate to their PC width, which wraps.
    function automatic logic [63:0] seq_next(input logic [63:0] pc, input int unsigned fetch_w);
        logic [63:0] step;
        step = 64'(4 * fetch_w);
        return (pc & ~(step - 64'd1)) + step;
    endfunction

endpackage

// File: rtl/npc_gen_if.sv
// Fetch-side bundle of the next-PC generator: redirect channels, predictor hint,
// fetch handshake and the generated PC. slave = npc_gen, master = surrounding pipeline.
interface npc_gen_if #(
    parameter int unsigned PC_W  = 32,
    parameter int unsigned N_RDR = 4
);

    logic                    if_ready;
    logic [N_RDR-1:0]        rdr_valid;
    logic [N_RDR*PC_W-1:0]   rdr_target;
    logic                    pred_taken;
    logic [PC_W-1:0]         pred_target;
    logic [PC_W-1:0]         pc_if;
    logic [PC_W-1:0]         npc;
    logic                    flush_if;
    logic                    pend_valid;
    logic                    addr_err;

    modport master (
        output if_ready, rdr_valid, rdr_target, pred_taken, pred_target,
        input  pc_if, npc, flush_if, pend_valid, addr_err
    );

    modport slave (
        input  if_ready, rdr_valid, rdr_target, pred_taken, pred_target,
        output pc_if, npc, flush_if, pend_valid, addr_err
    );

endinterface

// File: rtl/npc_rdr_arb.sv
// Fixed-priority redirect encoder: the lowest-numbered valid channel wins.
module npc_rdr_arb import npc_pkg::*; #(
    parameter int unsigned PC_W  = DEF_PC_W,
    parameter int unsigned N_RDR = 4,
    localparam int unsigned IDX_W = idx_width(N_RDR)
) (
    input  logic [N_RDR-1:0]      rdr_valid,
    input  logic [N_RDR*PC_W-1:0] rdr_target,
    output logic                  any_valid,
    output logic [IDX_W-1:0]      live_idx,
    output logic [PC_W-1:0]       live_tgt
);

    always_comb begin
        any_valid = 1'b0;
        live_idx  = '0;
        live_tgt  = '0;
        for (int unsigned i = 0; i < N_RDR; i++) begin
            if (rdr_valid[i] && !any_valid) begin
                any_valid = 1'b1;
                live_idx  = IDX_W'(i);
                live_tgt  = rdr_target[i*PC_W +: PC_W];
            end
        end
    end

endmodule

// File: rtl/npc_gen.sv
// Next-PC generator with a one-entry buffer for redirects raised while fetch stalls.
// Optional misaligned-PC flag built only when NPC_ADDR_ERR_EN is defined.
module npc_gen import npc_pkg::*; #(
    parameter int unsigned     PC_W     = DEF_PC_W,
    parameter int unsigned     FETCH_W  = 1,
    parameter int unsigned     N_RDR    = 4,
    parameter logic [PC_W-1:0] RESET_PC = PC_W'(DEF_RESET_PC)
) (
    input logic     clk,
    input logic     rst,
    npc_gen_if.slave bus
);

    localparam int unsigned IDX_W = idx_width(N_RDR);

    logic             any_valid;
    logic [IDX_W-1:0] live_idx;
    logic [PC_W-1:0]  live_tgt;
    logic             live_wins;

    pend_state_e      state_q, state_d;
    logic [PC_W-1:0]  pend_tgt_q, pend_tgt_d;
    logic [IDX_W-1:0] pend_idx_q, pend_idx_d;
    logic [PC_W-1:0]  pc_q;
    logic [PC_W-1:0]  npc_c;
    logic [PC_W-1:0]  seq_pc;

    npc_rdr_arb #(
        .PC_W  (PC_W),
        .N_RDR (N_RDR)
    ) u_arb (
        .rdr_valid  (bus.rdr_valid),
        .rdr_target (bus.rdr_target),
        .any_valid  (any_valid),
        .live_idx   (live_idx),
        .live_tgt   (live_tgt)
    );

    assign seq_pc = PC_W'(seq_next(64'(pc_q), FETCH_W));

    // A live redirect younger than the buffered one is dropped: it was already flushed.
    assign live_wins = any_valid && ((state_q == IDLE) || (live_idx <= pend_idx_q));

    always_comb begin
        npc_c = pc_q;
        if (!rst) begin
            npc_c = RESET_PC;
        end else if (bus.if_ready) begin
            if (live_wins) begin
                npc_c = live_tgt;
            end else if (state_q == PEND) begin
                npc_c = pend_tgt_q;
            end else if (bus.pred_taken) begin
                npc_c = bus.pred_target;
            end else begin
                npc_c = seq_pc;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        pend_tgt_d = pend_tgt_q;
        pend_idx_d = pend_idx_q;
        if (bus.if_ready) begin
            state_d = IDLE;
        end else if (live_wins) begin
            state_d    = PEND;
            pend_tgt_d = live_tgt;
            pend_idx_d = live_idx;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            pend_tgt_q <= '0;
            pend_idx_q <= '0;
            pc_q       <= RESET_PC;
        end else begin
            state_q    <= state_d;
            pend_tgt_q <= pend_tgt_d;
            pend_idx_q <= pend_idx_d;
            pc_q       <= npc_c;
        end
    end

`ifdef NPC_ADDR_ERR_EN
    logic addr_err_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_err_q <= 1'b0;
        end else begin
            addr_err_q <= (npc_c[1:0] != 2'b00);
        end
    end

    assign bus.addr_err = addr_err_q;
`else
    assign bus.addr_err = 1'b0;
`endif

    assign bus.pc_if      = pc_q;
    assign bus.npc        = npc_c;
    assign bus.flush_if   = live_wins;
    assign bus.pend_valid = (state_q == PEND);

endmodule

// File: tb/tb_npc_gen.sv
// Scoreboard bench for npc_gen: each driven cycle pushes its expected flush/pc_if/pend_valid,
// a monitor pops and compares after the edge. A FETCH_W=4 twin shares the stimulus.
module tb_npc_gen;

    localparam logic [31:0] RST_PC = 32'h1c00_0000;

    typedef struct {
        string       tag;
        logic [31:0] pc;
        logic        pend;
        logic        flush;
    } exp_t;

    logic clk;
    logic rst;
    logic flush_smp;
    int   n_vec;
    int   n_bad;
    exp_t sb[$];

    npc_gen_if #(.PC_W(32), .N_RDR(4)) b1 ();
    npc_gen_if #(.PC_W(32), .N_RDR(4)) b4 ();

    assign b4.if_ready    = b1.if_ready;
    assign b4.rdr_valid   = b1.rdr_valid;
    assign b4.rdr_target  = b1.rdr_target;
    assign b4.pred_taken  = b1.pred_taken;
    assign b4.pred_target = b1.pred_target;

    npc_gen #(.PC_W(32), .FETCH_W(1), .N_RDR(4), .RESET_PC(RST_PC)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (b1)
    );

    npc_gen #(.PC_W(32), .FETCH_W(4), .N_RDR(4), .RESET_PC(RST_PC)) u_dut4 (
        .clk (clk),
        .rst (rst),
        .bus (b4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Drive one cycle of stimulus and queue what must be seen for it.
    task automatic step(input string tag, input logic rdy, input logic [3:0] v, input int ch,
                        input logic [31:0] tgt, input logic e_flush, input logic [31:0] e_pc,
                        input logic e_pend);
        exp_t it;
        b1.if_ready  = rdy;
        b1.rdr_valid = v;
        if (v != 4'b0000) b1.rdr_target[ch*32 +: 32] = tgt;
        it.tag   = tag;
        it.pc    = e_pc;
        it.pend  = e_pend;
        it.flush = e_flush;
        sb.push_back(it);
        @(posedge clk);
        #2;
    endtask

    initial begin
        exp_t it;
        logic aexp;
        forever begin
            @(negedge clk);
            flush_smp = b1.flush_if;
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                it = sb.pop_front();
`ifdef NPC_ADDR_ERR_EN
                aexp = (it.pc[1:0] != 2'b00);
`else
                aexp = 1'b0;
`endif
                check({it.tag, "_flush"}, {31'd0, flush_smp}, {31'd0, it.flush});
                check({it.tag, "_pc"}, b1.pc_if, it.pc);
                check({it.tag, "_pend"}, {31'd0, b1.pend_valid}, {31'd0, it.pend});
                check({it.tag, "_aerr"}, {31'd0, b1.addr_err}, {31'd0, aexp});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        n_vec = 0;
        n_bad = 0;
        rst            = 1'b0;
        b1.if_ready    = 1'b1;
        b1.rdr_valid   = '0;
        b1.rdr_target  = '0;
        b1.pred_taken  = 1'b0;
        b1.pred_target = '0;
        repeat (3) @(posedge clk);
        #2;
        check("rst_pc", b1.pc_if, RST_PC);
        check("rst_npc", b1.npc, RST_PC);
        check("rst_pend", {31'd0, b1.pend_valid}, 32'd0);
        check("rst_aerr", {31'd0, b1.addr_err}, 32'd0);
        check("rst_pc_fw4", b4.pc_if, RST_PC);
        rst = 1'b1;
        #1;
        check("rel_pc", b1.pc_if, RST_PC);
        #1;

        // sequential fetch, FETCH_W=1 and 4
        step("seq1", 1, 4'b0000, 0, 0, 0, 32'h1c00_0004, 0);
        step("seq2", 1, 4'b0000, 0, 0, 0, 32'h1c00_0008, 0);
        check("fw4_seq", b4.pc_if, 32'h1c00_0020);
        step("rdr0", 1, 4'b0001, 0, 32'h1c00_0014, 1, 32'h1c00_0014, 0);
        check("fw4_rdr", b4.pc_if, 32'h1c00_0014);
        step("seq_w", 1, 4'b0000, 0, 0, 0, 32'h1c00_0018, 0);
        check("fw4_align", b4.pc_if, 32'h1c00_0020);

        // stalled redirects: higher priority overwrites the buffer
        step("stall_r3", 0, 4'b1000, 3, 32'h1c00_0100, 1, 32'h1c00_0018, 1);
        step("stall_r1", 0, 4'b0010, 1, 32'h1c00_0200, 1, 32'h1c00_0018, 1);
        step("rel", 1, 4'b0000, 0, 0, 0, 32'h1c00_0200, 0);

        // younger redirect in PEND is dropped
        step("p_r1", 0, 4'b0010, 1, 32'h1c00_0300, 1, 32'h1c00_0200, 1);
        step("p_r3", 0, 4'b1000, 3, 32'h1c00_0500, 0, 32'h1c00_0200, 1);
        step("p_rel", 1, 4'b0000, 0, 0, 0, 32'h1c00_0300, 0);
        step("p2_r1", 0, 4'b0010, 1, 32'h1c00_0340, 1, 32'h1c00_0300, 1);
        step("p2_r0", 1, 4'b0001, 0, 32'h1c00_0600, 1, 32'h1c00_0600, 0);
        step("eq_r1", 0, 4'b0010, 1, 32'h1c00_0700, 1, 32'h1c00_0600, 1);
        step("eq_win", 1, 4'b0010, 1, 32'h1c00_0780, 1, 32'h1c00_0780, 0);

        // predictor hint: loses to live redirect and to a pending one
        b1.pred_taken  = 1'b1;
        b1.pred_target = 32'h1c00_0400;
        step("pred_rdr", 1, 4'b0001, 0, 32'h1c00_0800, 1, 32'h1c00_0800, 0);
        step("pred", 1, 4'b0000, 0, 0, 0, 32'h1c00_0400, 0);
        step("pp_stall", 0, 4'b0100, 2, 32'h1c00_0900, 1, 32'h1c00_0400, 1);
        step("pp_rel", 1, 4'b0000, 0, 0, 0, 32'h1c00_0900, 0);
        b1.pred_taken = 1'b0;

        // top-of-space wrap
        step("to_top", 1, 4'b0001, 0, 32'hffff_fffc, 1, 32'hffff_fffc, 0);
        step("wrap", 1, 4'b0000, 0, 0, 0, 32'h0000_0000, 0);
        check("fw4_wrap", b4.pc_if, 32'h0000_0000);
        step("after_wrap", 1, 4'b0000, 0, 0, 0, 32'h0000_0004, 0);

        // misaligned target, then plain stall hold
        step("misalign", 1, 4'b0001, 0, 32'h1c00_0102, 1, 32'h1c00_0102, 0);
        step("mis_seq", 1, 4'b0000, 0, 0, 0, 32'h1c00_0104, 0);
        step("hold", 0, 4'b0000, 0, 0, 0, 32'h1c00_0104, 0);

        // reset mid-stall discards the buffered redirect
        step("rst_stall", 0, 4'b0100, 2, 32'h1c00_0a00, 1, 32'h1c00_0104, 1);
        rst = 1'b0;
        #1;
        check("mid_rst_pc", b1.pc_if, RST_PC);
        check("mid_rst_npc", b1.npc, RST_PC);
        check("mid_rst_pend", {31'd0, b1.pend_valid}, 32'd0);
        b1.if_ready  = 1'b1;
        b1.rdr_valid = '0;
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("post_rst_pc", b1.pc_if, RST_PC);
        #1;
        step("post_rst", 1, 4'b0000, 0, 0, 0, 32'h1c00_0004, 0);

        @(posedge clk);
        #2;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/npc_gen.md
NPC_GEN -- requirements
Module: npc_gen

Interface
REQ-001 Parameter PC_W, default 32: PC width in bits.
REQ-002 Parameter FETCH_W, default 1: instructions per fetch block; legal values 1, 2, 4.
REQ-003 Parameter N_RDR, default 4: redirect channel count; index 0 is the highest priority.
REQ-004 Parameter RESET_PC, default 32'h1c00_0000: PC value after reset.
REQ-005 clk  in  1  single clock; all state updates on its rising edge.
REQ-006 rst  in  1  asynchronous, active-low reset.
REQ-007 if_ready  in  1  fetch stage accepts a new PC this cycle.
REQ-008 rdr_valid  in  N_RDR  per-channel redirect request (exception, ertn, jr, mispredict, ...).
REQ-009 rdr_target  in  N_RDR*PC_W  per-channel target; channel i occupies bits [i*PC_W +: PC_W].
REQ-010 pred_taken  in  1  branch predictor taken hint for pc_if.
REQ-011 pred_target  in  PC_W  predicted target.
REQ-012 pc_if  out  PC_W  registered current fetch PC.
REQ-013 npc  out  PC_W  combinational value that pc_if loads at the next edge.
REQ-014 flush_if  out  1  kill in-flight fetch; combinational.
REQ-015 pend_valid  out  1  a redirect is buffered; registered.
REQ-016 addr_err  out  1  misaligned pc_if; registered; present only under the macro in REQ-031.

Function
REQ-017 Live redirect = lowest set index of rdr_valid; its target and index are called live_tgt and live_idx.
REQ-018 With if_ready=1, npc selection in priority order:
- live_tgt, when live redirect exists and (state IDLE or live_idx <= pend_idx);
- otherwise pend_tgt, when state PEND;
- otherwise pred_target, when pred_taken;
- otherwise sequential next.
REQ-019 With if_ready=0, npc SHALL equal pc_if.
REQ-020 pc_if SHALL load npc every cycle; pc_if is therefore held while if_ready=0.
REQ-021 Sequential next SHALL be (pc_if & ~(4*FETCH_W-1)) + 4*FETCH_W, computed modulo 2^PC_W; the top-of-space address wraps to 0.
REQ-022 Pending FSM states are IDLE and PEND, with registers pend_tgt and pend_idx.
REQ-023 IDLE -> PEND when a live redirect occurs with if_ready=0; capture live_tgt and live_idx.
REQ-024 In PEND with if_ready=0 and a live redirect:
- live_idx <= pend_idx: overwrite pend_tgt and pend_idx;
- live_idx > pend_idx: ignore the redirect (younger instruction, already flushed).
REQ-025 PEND -> IDLE on any cycle with if_ready=1; npc follows REQ-018, so a simultaneous higher-or-equal-priority live redirect wins over the buffered one.
REQ-026 flush_if SHALL be 1 in any cycle with a live redirect that is not ignored under REQ-024, regardless of if_ready; otherwise 0.
REQ-027 pred_taken SHALL be ignored while a redirect is live or state is PEND.
REQ-028 Latency: a redirect with if_ready=1 appears on pc_if one cycle later; a redirect raised during a stall appears one cycle after if_ready rises.

Reset
REQ-029 While rst=0: pc_if = RESET_PC, npc = RESET_PC, state = IDLE, pend_valid = 0, pend_tgt = 0, pend_idx = 0, addr_err = 0.
REQ-030 Reset asserted mid-stall SHALL discard any pending redirect; the first fetch after release is RESET_PC.

Configuration
REQ-031 Macro NPC_ADDR_ERR_EN:
- defined: addr_err register loads (npc[1:0] != 0) whenever pc_if loads;
- undefined: addr_err tied to 0 and its register is not built.

Structure
REQ-032 Shared package npc_pkg holds:
- default PC_W and RESET_PC constants;
- pending-FSM state enum {IDLE, PEND};
- function seq_next(pc, fetch_w).
REQ-033 One sub-module, npc_rdr_arb: N_RDR-input priority encoder producing any_valid, live_idx and live_tgt.

Verification
REQ-034 Release rst, hold if_ready=1, FETCH_W=1 -> pc_if sequence 1c000000, 1c000004, 1c000008.
REQ-035 FETCH_W=4 with pc_if=1c000014 -> next pc_if = 1c000020.
REQ-036 if_ready=0; rdr_valid=4'b1000 with target 1c000100; then rdr_valid=4'b0010 with target 1c000200; then if_ready=1 -> flush_if pulses both times, pend_valid=1, and the next pc_if = 1c000200.
REQ-037 In PEND with idx 1, channel 3 redirect during the stall -> ignored, flush_if=0, pc_if later = pend_tgt; channel 0 redirect with if_ready=1 -> pc_if = channel 0 target.
REQ-038 pred_taken=1 with target 1c000400 while rdr_valid=0001 (target 1c000800) -> pc_if = 1c000800; PC_W=32 with pc_if=fffffffc, no redirect -> pc_if = 0.
REQ-039 With NPC_ADDR_ERR_EN, redirect target 1c000102 -> addr_err=1 with that pc_if; rst=0 mid-stall in PEND -> pend_valid=0 and pc_if=RESET_PC immediately.
